// File: rtl/rxd_sample_gen_pkg.sv
// ---------------------------------------------------------------------------
// rxd_pkg
//   Shared definitions for the UART RX timing engine.
//   - rxd_state_t : receiver FSM state (IDLE / RECV)
//   - FRAME_BITS_DEF, OVS_DEF : default frame length and oversample ratio
//   - maj3 : 3-input majority vote used at each bit centre
// ---------------------------------------------------------------------------
package rxd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rxd_state_t;

  localparam int FRAME_BITS_DEF = 10;
  localparam int OVS_DEF        = 16;

  // Majority of three samples: true when at least two inputs are 1.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rxd_prescaler.sv
// ---------------------------------------------------------------------------
// rxd_prescaler
//   Holds the runtime divisor and produces the oversample tick.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     en         : receiver is in RECV; counter runs only while set
//     clr        : receiver leaves RECV this cycle; counter returns to 0
//     load       : request to load div_val (honoured only while !en)
//     div_val    : clocks per oversample tick minus 1 (values <2 become 2)
//     os_tick    : 1-cycle tick, decoded from registers only
// ---------------------------------------------------------------------------
module rxd_prescaler
  import rxd_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 324
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  output logic             os_tick
);

  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] div_q_r;
  logic [DIV_W-1:0] pre_cnt_r;
  logic [DIV_W-1:0] div_clamped_s;
  logic             load_ok_s;

  // Clamp the requested divisor so a tick period is never shorter than 3 clocks.
  always_comb begin
    div_clamped_s = div_val;
    if (div_val < DIV_MIN) begin
      div_clamped_s = DIV_MIN;
    end else begin
      div_clamped_s = div_val;
    end
  end

  // The divisor may only change between frames, never mid-frame.
  assign load_ok_s = load & ~en;

  // Divisor register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q_r <= DIV_RESET;
    end else if (load_ok_s) begin
      div_q_r <= div_clamped_s;
    end else begin
      div_q_r <= div_q_r;
    end
  end

  // Prescaler counter: 0..div_q, held at 0 outside RECV and when leaving it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_r <= {DIV_W{1'b0}};
    end else if (!en || clr) begin
      pre_cnt_r <= {DIV_W{1'b0}};
    end else if (pre_cnt_r == div_q_r) begin
      pre_cnt_r <= {DIV_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + DIV_W'(1);
    end
  end

  assign os_tick = en & (pre_cnt_r == div_q_r);

endmodule

// File: rtl/rxd_sample_gen.sv
// ---------------------------------------------------------------------------
// rxd_sample_gen
//   UART RX timing engine: oversampled bit timing, 3-sample majority vote at
//   each bit centre, start-bit qualification and frame bit counting.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     rxd         : synchronised serial input
//     rx_start    : falling edge seen on rxd, arms a frame (IDLE only)
//     rx_abort    : cancels the current frame; beats every other event
//     div_load    : load div_val into the divisor (IDLE only)
//     div_val     : clocks per oversample tick minus 1
//     os_tick     : oversample tick pulse
//     bit_strobe  : bit-centre strobe pulse
//     bit_val     : voted bit value (with bit_strobe, else 0)
//     bit_idx     : bit index in frame, 0 = start (with bit_strobe, else 0)
//     rx_done     : pulses with the strobe of the last frame bit
//     start_err   : pulses when the voted start bit is 1
//     busy        : receiver is in RECV
// ---------------------------------------------------------------------------
module rxd_sample_gen
  import rxd_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BPS           = 9600,
  parameter int OVS           = OVS_DEF,
  parameter int DIV_W         = 16,
  parameter int FRAME_BITS    = FRAME_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          rx_start,
  input  logic                          rx_abort,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_val,
  output logic                          os_tick,
  output logic                          bit_strobe,
  output logic                          bit_val,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          rx_done,
  output logic                          start_err,
  output logic                          busy
);

  localparam int DEF_DIV = CLK_FREQUENCE / (BPS * OVS) - 1;
  localparam int PH_W    = $clog2(OVS);
  localparam int IDX_W   = $clog2(FRAME_BITS);

  // Vote samples are taken on the two ticks before the strobe tick; the
  // strobe tick supplies the third sample straight from rxd.
  localparam logic [PH_W-1:0]  PH_VOTE0 = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0]  PH_VOTE1 = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0]  PH_STB   = PH_W'(OVS / 2 + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  rxd_state_t       state_r;
  rxd_state_t       state_nxt_s;
  logic             os_tick_s;
  logic             leave_s;
  logic [PH_W-1:0]  ph_cnt_r;
  logic [IDX_W-1:0] bit_cnt_r;
  logic [1:0]       vote_r;
  logic             voted_s;
  logic             strobe_s;
  logic             done_s;
  logic             serr_s;

  logic             bit_strobe_r;
  logic             bit_val_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic             rx_done_r;
  logic             start_err_r;
  logic             busy_r;

  rxd_prescaler #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_r == RECV),
    .clr     (leave_s),
    .load    (div_load),
    .div_val (div_val),
    .os_tick (os_tick_s)
  );

  // Bit-centre decode: vote result plus strobe/done/false-start events.
  always_comb begin
    voted_s  = maj3(vote_r[1], vote_r[0], rxd);
    strobe_s = 1'b0;
    done_s   = 1'b0;
    serr_s   = 1'b0;
    if (os_tick_s && !rx_abort && (ph_cnt_r == PH_STB)) begin
      strobe_s = 1'b1;
      done_s   = (bit_cnt_r == IDX_LAST);
      serr_s   = (bit_cnt_r == {IDX_W{1'b0}}) && voted_s;
    end else begin
      strobe_s = 1'b0;
      done_s   = 1'b0;
      serr_s   = 1'b0;
    end
  end

  // Next-state logic; abort takes priority in both states.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_start && !rx_abort) begin
          state_nxt_s = RECV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECV: begin
        if (rx_abort || serr_s || done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RECV;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign leave_s = (state_r == RECV) && (state_nxt_s == IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Phase, bit counter and vote shift register; all cleared outside RECV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_cnt_r  <= {PH_W{1'b0}};
      bit_cnt_r <= {IDX_W{1'b0}};
      vote_r    <= 2'b00;
    end else if ((state_r != RECV) || leave_s) begin
      ph_cnt_r  <= {PH_W{1'b0}};
      bit_cnt_r <= {IDX_W{1'b0}};
      vote_r    <= 2'b00;
    end else if (os_tick_s) begin
      if (ph_cnt_r == PH_LAST) begin
        ph_cnt_r  <= {PH_W{1'b0}};
        bit_cnt_r <= bit_cnt_r + IDX_W'(1);
      end else begin
        ph_cnt_r  <= ph_cnt_r + PH_W'(1);
      end
      if ((ph_cnt_r == PH_VOTE0) || (ph_cnt_r == PH_VOTE1)) begin
        vote_r <= {vote_r[0], rxd};
      end else begin
        vote_r <= vote_r;
      end
    end else begin
      ph_cnt_r  <= ph_cnt_r;
      bit_cnt_r <= bit_cnt_r;
      vote_r    <= vote_r;
    end
  end

  // Output registers; value/index are forced to 0 between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_strobe_r <= 1'b0;
      bit_val_r    <= 1'b0;
      bit_idx_r    <= {IDX_W{1'b0}};
      rx_done_r    <= 1'b0;
      start_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      bit_strobe_r <= strobe_s;
      bit_val_r    <= strobe_s ? voted_s : 1'b0;
      bit_idx_r    <= strobe_s ? bit_cnt_r : {IDX_W{1'b0}};
      rx_done_r    <= done_s;
      start_err_r  <= serr_s;
      busy_r       <= (state_nxt_s == RECV);
    end
  end

  assign os_tick    = os_tick_s;
  assign bit_strobe = bit_strobe_r;
  assign bit_val    = bit_val_r;
  assign bit_idx    = bit_idx_r;
  assign rx_done    = rx_done_r;
  assign start_err  = start_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_rxd_sample_gen.sv
// ---------------------------------------------------------------------------
// tb_rxd_sample_gen
//   Directed bench for rxd_sample_gen. A timing model computes, from the
//   frame start cycle and divisor, when every tick and bit strobe must occur
//   and what each vote must be; all outputs are compared every cycle. A few
//   literal expectations pin the model (bit patterns, tick spacing, latency).
// ---------------------------------------------------------------------------
module tb_rxd_sample_gen;

  localparam int OVS     = 16;
  localparam int FB      = 10;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 324;
  localparam int HIST    = 16384;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rxd;
  logic             rx_start;
  logic             rx_abort;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             os_tick;
  logic             bit_strobe;
  logic             bit_val;
  logic [3:0]       bit_idx;
  logic             rx_done;
  logic             start_err;
  logic             busy;

  always #5 clk = ~clk;

  rxd_sample_gen #(
    .CLK_FREQUENCE (50_000_000),
    .BPS           (9600),
    .OVS           (OVS),
    .DIV_W         (DIV_W),
    .FRAME_BITS    (FB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_start   (rx_start),
    .rx_abort   (rx_abort),
    .div_load   (div_load),
    .div_val    (div_val),
    .os_tick    (os_tick),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .bit_idx    (bit_idx),
    .rx_done    (rx_done),
    .start_err  (start_err),
    .busy       (busy)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // timing model state
  bit         m_busy = 1'b0;
  int         m_t0   = 0;
  int         m_d    = 1;
  int         m_divq = DEF_DIV;
  logic       e_stb  = 1'b0;
  logic       e_val  = 1'b0;
  logic [3:0] e_idx  = 4'd0;
  logic       e_done = 1'b0;
  logic       e_serr = 1'b0;
  logic       e_busy = 1'b0;
  logic       rxd_hist [HIST];

  // observations used by the literal checks
  int         n_stb = 0, n_done = 0, n_serr = 0;
  int         last_tick = 0, tick_gap = 0, stb0_cyc = 0, done_idx = 0;
  logic [9:0] got_bits = 10'd0;

  localparam logic [9:0] FRAME_55 = {1'b1, 8'h55, 1'b0};

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compare this cycle's outputs, record observations, advance the model
  // across the coming edge using the inputs now applied.
  task automatic cycle_check();
    logic [9:0] got, exp;
    logic       tick_e;
    int         el, q, r, k, cnt;
    tick_e = m_busy && (((cyc - m_t0 + 1) % m_d) == 0);
    exp = {tick_e, e_stb, e_val, e_idx, e_done, e_serr, e_busy};
    got = {os_tick, bit_strobe, bit_val, bit_idx, rx_done, start_err, busy};
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d outputs{tick,stb,val,idx,done,serr,busy}: got %b, expected %b", cyc, got, exp);
    end

    if (os_tick === 1'b1) begin tick_gap = cyc - last_tick; last_tick = cyc; end
    if (bit_strobe === 1'b1) begin
      n_stb++;
      got_bits[bit_idx] = bit_val;
      if (bit_idx == 4'd0) stb0_cyc = cyc;
    end
    if (rx_done === 1'b1) begin n_done++; done_idx = int'(bit_idx); end
    if (start_err === 1'b1) n_serr++;
    rxd_hist[cyc % HIST] = rxd;

    e_stb = 1'b0; e_val = 1'b0; e_idx = 4'd0; e_done = 1'b0; e_serr = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_divq = DEF_DIV;
    end else if (m_busy) begin
      if (rx_abort) begin
        m_busy = 1'b0;
      end else begin
        // bit k is strobed (div+1)*(k*OVS+OVS/2+2) clocks after the entering edge
        el = cyc + 1 - m_t0;
        if ((el % m_d) == 0) begin
          q = el / m_d;
          r = q - (OVS / 2 + 2);
          if (r >= 0 && (r % OVS) == 0) begin
            k   = r / OVS;
            cnt = 0;
            for (int j = 0; j < 3; j++)
              cnt += int'(rxd_hist[(m_t0 + m_d * (k * OVS + OVS / 2 + j) - 1) % HIST]);
            e_stb  = 1'b1;
            e_val  = (cnt >= 2);
            e_idx  = 4'(k);
            e_done = (k == FB - 1);
            e_serr = (k == 0) && e_val;
            if (e_done || e_serr) m_busy = 1'b0;
          end
        end
      end
    end else begin
      if (div_load) m_divq = (div_val < 16'd2) ? 2 : int'(div_val);
      if (rx_start && !rx_abort) begin
        m_busy = 1'b1;
        m_t0   = cyc + 1;
        m_d    = m_divq + 1;
      end
    end
    e_busy = m_busy;
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Pulse rx_start and play a frame; d is the bench's own idea of the
  // divisor+1 used to shape rxd. inv_lo..inv_hi invert rxd (elapsed clocks),
  // abort_at / load_at pulse rx_abort / div_load(7) at that elapsed clock.
  task automatic run_frame(input logic [9:0] fb, input int d, input int ncyc,
                           input int inv_lo, input int inv_hi,
                           input int abort_at, input int load_at, output int t0);
    int el, b;
    t0 = cyc + 1;
    rx_start = 1'b1;
    rxd      = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      rx_start = 1'b0;
      el = cyc - t0;
      b  = el / (d * OVS);
      rxd = (b > FB - 1) ? 1'b1 : fb[b];
      if (el >= inv_lo && el <= inv_hi) rxd = ~rxd;
      rx_abort = (el == abort_at);
      div_load = (el == load_at);
      div_val  = 16'd7;
    end
    rxd = 1'b1; rx_abort = 1'b0; div_load = 1'b0; div_val = 16'd0;
    step();
  endtask

  initial begin
    int t0, s_stb, s_done, s_serr;
    rst_n = 1'b0; rxd = 1'b1; rx_start = 1'b0; rx_abort = 1'b0;
    div_load = 1'b0; div_val = 16'd0;
    @(posedge clk);
    #2;
    cyc = 1;
    step();
    step();
    check_lit("reset_outputs", {os_tick, bit_strobe, bit_val, bit_idx, rx_done, start_err, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // rx_start with rx_abort in IDLE: abort wins
    rx_start = 1'b1; rx_abort = 1'b1;
    step();
    rx_start = 1'b0; rx_abort = 1'b0;
    check_lit("start_abort_idle_busy", busy, 32'd0);
    step();

    // divisor 3 -> 4 clocks per tick, 64 per bit
    div_load = 1'b1; div_val = 16'd3;
    step();
    div_load = 1'b0; div_val = 16'd0;

    // frame 0x55 with a load attempt of 7 while busy
    s_done = n_done; s_serr = n_serr;
    run_frame(FRAME_55, 4, 640, 1, 0, -1, 100, t0);
    check_lit("f55_bits", got_bits, 32'b1010101010);
    check_lit("f55_done_cnt", n_done - s_done, 32'd1);
    check_lit("f55_done_idx", done_idx, 32'd9);
    check_lit("f55_no_serr", n_serr - s_serr, 32'd0);
    check_lit("f55_strobe0_latency", stb0_cyc - t0, 32'd40);
    check_lit("busy_load_ignored_gap", tick_gap, 32'd4);
    check_lit("f55_busy_after", busy, 32'd0);

    // glitch start: low for 8 clocks only
    s_stb = n_stb; s_done = n_done; s_serr = n_serr;
    run_frame(10'h3FF, 4, 60, 0, 6, -1, -1, t0);
    check_lit("glitch_serr", n_serr - s_serr, 32'd1);
    check_lit("glitch_no_done", n_done - s_done, 32'd0);
    check_lit("glitch_one_strobe", n_stb - s_stb, 32'd1);
    check_lit("glitch_val", got_bits[0], 32'd1);
    check_lit("glitch_busy", busy, 32'd0);

    // majority: data bit 3 (frame bit 4) inverted at phase 8 only
    run_frame(FRAME_55, 4, 640, 291, 291, -1, -1, t0);
    check_lit("maj_single_outlier", got_bits, 32'b1010101010);
    // inverted across phases 7..9 -> bit flips
    run_frame(FRAME_55, 4, 640, 287, 295, -1, -1, t0);
    check_lit("maj_three_flip", got_bits, 32'b1010111010);

    // abort inside bit 4
    s_stb = n_stb; s_done = n_done; s_serr = n_serr;
    run_frame(FRAME_55, 4, 400, 1, 0, 276, -1, t0);
    check_lit("abort_strobes", n_stb - s_stb, 32'd4);
    check_lit("abort_no_done", n_done - s_done, 32'd0);
    check_lit("abort_no_serr", n_serr - s_serr, 32'd0);
    check_lit("abort_busy", busy, 32'd0);

    // div_val 0 in IDLE clamps to 2 -> 3 clocks per tick
    div_load = 1'b1; div_val = 16'd0;
    step();
    div_load = 1'b0;
    run_frame(FRAME_55, 3, 100, 1, 0, 90, -1, t0);
    check_lit("clamp_gap", tick_gap, 32'd3);

    // mid-frame reset restores the default divisor
    run_frame(FRAME_55, 3, 30, 1, 0, -1, -1, t0);
    check_lit("busy_before_reset", busy, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_lit("midframe_reset_outputs", {os_tick, bit_strobe, bit_val, bit_idx, rx_done, start_err, busy}, 32'd0);
    step();
    run_frame(FRAME_55, 325, 700, 1, 0, 680, -1, t0);
    check_lit("default_div_gap", tick_gap, 32'd325);

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
